i2s_deserializer: RTL

//   Upstream stage of the echo delay line: converts the codec's serial I2S ADC stream into

---
 rtl/i2s_deserializer_if.sv | 29 ++
 rtl/i2s_deserializer.sv | 110 +++++++++++
 2 files changed

// File: rtl/i2s_deserializer_if.sv
// Parallel-side bundle of the I2S ADC deserializer: serial inputs in, stereo pair and status out.
interface i2s_deserializer_if #(
  parameter int DATALEN = 16
) ();
  logic               lrclk;
  logic               sdin;
  logic [DATALEN-1:0] left_out;
  logic [DATALEN-1:0] right_out;
  logic               sample_valid;
  logic               frame_err;

  modport master (
    input  lrclk,
    input  sdin,
    output left_out,
    output right_out,
    output sample_valid,
    output frame_err
  );

  modport slave (
    output lrclk,
    output sdin,
    input  left_out,
    input  right_out,
    input  sample_valid,
    input  frame_err
  );
endinterface

// File: rtl/i2s_deserializer.sv
// I2S ADC deserializer: captures MSB-first slots in the bclk domain and emits a coherent
// left/right pair with a one-cycle strobe at each frame end, flagging bad slot lengths.
module i2s_deserializer #(
  parameter int DATALEN  = 16,
  parameter int SLOTBITS = 32
) (
  input  logic              bclk,
  input  logic              reset,
  i2s_deserializer_if.master bus
);

  localparam int               CW       = $clog2(SLOTBITS + 2);
  localparam logic [CW-1:0]    CNT_MAX  = CW'(SLOTBITS + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(SLOTBITS - 1);
  localparam logic [DATALEN-1:0] MSB_ONE = {1'b1, {(DATALEN-1){1'b0}}};

  typedef enum logic {
    ST_UNSYNC,
    ST_SYNC
  } state_e;

  state_e             state_q, state_d;
  logic               lr_q, lr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DATALEN-1:0] word_q, word_d;
  logic [DATALEN-1:0] hold_q, hold_d;
  logic [DATALEN-1:0] left_q, left_d;
  logic [DATALEN-1:0] right_q, right_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic               boundary;
  logic [DATALEN-1:0] word_done;

  always_comb begin
    boundary  = (bus.lrclk != lr_q);

    // Bits past DATALEN shift the marker out of the word, which truncates the slot.
    word_done = word_q;
    if (bus.sdin) begin
      word_done = word_q | (MSB_ONE >> cnt_q);
    end

    state_d = state_q;
    lr_d    = bus.lrclk;
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    word_d  = word_done;
    hold_d  = hold_q;
    left_d  = left_q;
    right_d = right_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (boundary) begin
      cnt_d  = '0;
      word_d = '0;
    end

    case (state_q)
      ST_UNSYNC: begin
        if (boundary) begin
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (boundary) begin
          err_d = (cnt_q != CNT_LAST);
          if (!lr_q) begin
            hold_d = word_done;
          end else begin
            right_d = word_done;
            left_d  = hold_q;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_UNSYNC;
    endcase
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      state_q <= ST_UNSYNC;
      lr_q    <= 1'b0;
      cnt_q   <= '0;
      word_q  <= '0;
      hold_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lr_q    <= lr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      hold_q  <= hold_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.left_out     = left_q;
  assign bus.right_out    = right_q;
  assign bus.sample_valid = valid_q;
  assign bus.frame_err    = err_q;

endmodule
